// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY receive path.
//   SYNC_DATA / SYNC_CTRL : the two legal 64b/66b sync header patterns
//   blk_lock_state_e      : block-lock FSM state encoding
//   sync_hdr_valid()      : header classifier (01/10 valid, 00/11 invalid)
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int LOCK_CNT_DEFAULT      = 64;
    localparam int INVALID_LIMIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HIGH = 2'd1,
        SLIP_WAIT = 2'd2,
        LOCKED    = 2'd3
    } blk_lock_state_e;

    function automatic logic sync_hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_slip_timer.sv
// Down-counter timing the bitslip high and settle phases.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length in cycles
//   done       : high during the last cycle of the loaded phase
module eth_phy_10g_rx_slip_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count of 1: a phase loaded with N spans exactly N cycles.
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/eth_phy_10g_rx_block_lock.sv
// 10GBASE-R receive block lock. Watches the sync header each rx_clk and
// requests bitslips from the SERDES gearbox until 64b/66b alignment holds.
//   rx_clk, rx_rst_n    : receive clock, asynchronous active-low reset
//   serdes_rx_hdr       : sync header from the SERDES
//   serdes_rx_bitslip   : slip request to the gearbox
//   serdes_rx_reset_req : one-cycle SERDES RX reset request after too many slips
//   rx_block_lock       : block alignment achieved
//   rx_hdr_invalid      : header sampled last cycle was invalid
//   rx_slip_count       : slips since last lock or reset request (saturating)
//
// state     | meaning
// HUNT      | counting consecutive valid headers toward lock
// SLIP_HIGH | bitslip asserted, headers ignored
// SLIP_WAIT | gearbox settling after a slip, headers ignored
// LOCKED    | aligned; invalid headers counted per window
module eth_phy_10g_rx_block_lock
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH           = 2,
    parameter int LOCK_CNT            = LOCK_CNT_DEFAULT,
    parameter int INVALID_LIMIT       = INVALID_LIMIT_DEFAULT,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int SLIP_LIMIT          = 66
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst_n,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    output logic                 serdes_rx_bitslip,
    output logic                 serdes_rx_reset_req,
    output logic                 rx_block_lock,
    output logic                 rx_hdr_invalid,
    output logic [6:0]           rx_slip_count
);

    localparam int SH_W    = $clog2(LOCK_CNT + 1);
    localparam int INV_W   = $clog2(INVALID_LIMIT + 1);
    localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                             BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [SH_W-1:0]  SH_LAST   = SH_W'(LOCK_CNT - 1);
    localparam logic [INV_W-1:0] INV_LAST  = INV_W'(INVALID_LIMIT - 1);
    localparam logic [TMR_W-1:0] TMR_HIGH  = TMR_W'(BITSLIP_HIGH_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOW   = TMR_W'(BITSLIP_LOW_CYCLES);
    localparam logic [6:0]       SLIP_LIM  = 7'(SLIP_LIMIT);
    localparam logic [6:0]       SLIP_SAT  = 7'h7f;

    blk_lock_state_e  state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [6:0]       slip_cnt_q, slip_cnt_d;
    logic             lock_q, lock_d;
    logic             bitslip_q, bitslip_d;
    logic             reset_req_q, reset_req_d;
    logic             hdr_inv_q, hdr_inv_d;

    logic             hdr_bad;
    logic [6:0]       slip_inc;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_done;

    eth_phy_10g_rx_slip_timer #(
        .CNT_W (TMR_W)
    ) u_slip_timer (
        .clk      (rx_clk),
        .rst_n    (rx_rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        inv_cnt_d    = inv_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        lock_d       = lock_q;
        bitslip_d    = bitslip_q;
        reset_req_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = TMR_HIGH;

        // Written as if/else so an X or Z header lands on the invalid side.
        if (sync_hdr_valid(serdes_rx_hdr[1:0])) begin
            hdr_bad = 1'b0;
        end else begin
            hdr_bad = 1'b1;
        end
        hdr_inv_d = hdr_bad;

        slip_inc = (slip_cnt_q == SLIP_SAT) ? slip_cnt_q : slip_cnt_q + 7'd1;

        case (state_q)
            HUNT: begin
                if (hdr_bad) begin
                    sh_cnt_d  = '0;
                    state_d   = SLIP_HIGH;
                    bitslip_d = 1'b1;
                    tmr_load  = 1'b1;
                    // Too many fruitless slips: ask for a SERDES reset, keep slipping.
                    if (slip_inc == SLIP_LIM) begin
                        reset_req_d = 1'b1;
                        slip_cnt_d  = '0;
                    end else begin
                        slip_cnt_d = slip_inc;
                    end
                end else if (sh_cnt_q == SH_LAST) begin
                    state_d    = LOCKED;
                    lock_d     = 1'b1;
                    sh_cnt_d   = '0;
                    slip_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + 1'b1;
                end
            end
            SLIP_HIGH: begin
                if (tmr_done) begin
                    bitslip_d = 1'b0;
                    if (BITSLIP_LOW_CYCLES == 0) begin
                        state_d = HUNT;
                    end else begin
                        state_d      = SLIP_WAIT;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_LOW;
                    end
                end
            end
            SLIP_WAIT: begin
                if (tmr_done) begin
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                // Loss of lock is tested first so it wins on the window's last header.
                if (hdr_bad && (inv_cnt_q == INV_LAST)) begin
                    state_d    = SLIP_HIGH;
                    lock_d     = 1'b0;
                    sh_cnt_d   = '0;
                    inv_cnt_d  = '0;
                    slip_cnt_d = slip_inc;
                    bitslip_d  = 1'b1;
                    tmr_load   = 1'b1;
                end else if (sh_cnt_q == SH_LAST) begin
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + 1'b1;
                    if (hdr_bad) begin
                        inv_cnt_d = inv_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= HUNT;
            sh_cnt_q    <= '0;
            inv_cnt_q   <= '0;
            slip_cnt_q  <= '0;
            lock_q      <= 1'b0;
            bitslip_q   <= 1'b0;
            reset_req_q <= 1'b0;
            hdr_inv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            inv_cnt_q   <= inv_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            lock_q      <= lock_d;
            bitslip_q   <= bitslip_d;
            reset_req_q <= reset_req_d;
            hdr_inv_q   <= hdr_inv_d;
        end
    end

    assign serdes_rx_bitslip   = bitslip_q;
    assign serdes_rx_reset_req = reset_req_q;
    assign rx_block_lock       = lock_q;
    assign rx_hdr_invalid      = hdr_inv_q;
    assign rx_slip_count       = slip_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock.sv
module tb_eth_phy_10g_rx_block_lock;

    localparam int LOCK_CNT   = 64;
    localparam int INV_LIM    = 16;
    localparam int HIGH       = 1;
    localparam int LOW        = 8;
    localparam int SLIP_LIMIT = 66;

    logic       rx_clk   = 1'b0;
    logic       rx_rst_n = 1'b1;
    logic [1:0] serdes_rx_hdr = 2'b10;
    logic       serdes_rx_bitslip;
    logic       serdes_rx_reset_req;
    logic       rx_block_lock;
    logic       rx_hdr_invalid;
    logic [6:0] rx_slip_count;

    eth_phy_10g_rx_block_lock #(
        .HDR_WIDTH           (2),
        .LOCK_CNT            (LOCK_CNT),
        .INVALID_LIMIT       (INV_LIM),
        .BITSLIP_HIGH_CYCLES (HIGH),
        .BITSLIP_LOW_CYCLES  (LOW),
        .SLIP_LIMIT          (SLIP_LIMIT)
    ) dut (
        .rx_clk              (rx_clk),
        .rx_rst_n            (rx_rst_n),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .rx_block_lock       (rx_block_lock),
        .rx_hdr_invalid      (rx_hdr_invalid),
        .rx_slip_count       (rx_slip_count)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct packed {
        logic       lock;
        logic       slip;
        logic       rreq;
        logic       inv;
        logic [6:0] cnt;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;
    int   slip_hi_seen = 0;
    int   rreq_seen = 0;

    // Reference model: rule-level bookkeeping of the alignment process.
    bit m_locked;
    int m_run;      // consecutive good headers while hunting
    int m_win;      // headers seen in the current locked window
    int m_bad;      // bad headers in the current locked window
    int m_ignore;   // headers still to be ignored after a slip
    int m_since;    // headers since the slip decision
    int m_slips;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_run    = 0;
        m_win    = 0;
        m_bad    = 0;
        m_ignore = 0;
        m_since  = HIGH;
        m_slips  = 0;
    endfunction

    function automatic void model_start_slip();
        m_ignore = HIGH + LOW;
        m_since  = 0;
    endfunction

    function automatic obs_t model_step(input logic [1:0] h);
        obs_t o;
        bit good;
        good   = (h == 2'b01) || (h == 2'b10);
        o.rreq = 1'b0;
        if (m_ignore > 0) begin
            m_ignore = m_ignore - 1;
            m_since  = m_since + 1;
        end else if (!m_locked) begin
            if (good) begin
                m_run = m_run + 1;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                    m_slips  = 0;
                end
            end else begin
                m_run   = 0;
                m_slips = (m_slips < 127) ? m_slips + 1 : 127;
                if (m_slips == SLIP_LIMIT) begin
                    o.rreq  = 1'b1;
                    m_slips = 0;
                end
                model_start_slip();
            end
        end else begin
            m_win = m_win + 1;
            if (!good) m_bad = m_bad + 1;
            if (m_bad == INV_LIM) begin
                m_locked = 1'b0;
                m_win    = 0;
                m_bad    = 0;
                m_slips  = (m_slips < 127) ? m_slips + 1 : 127;
                model_start_slip();
            end else if (m_win == LOCK_CNT) begin
                m_win = 0;
                m_bad = 0;
            end
        end
        o.lock = m_locked;
        o.slip = (m_since < HIGH);
        o.inv  = !good;
        o.cnt  = m_slips[6:0];
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; the header is sampled on the next rising edge.
    task automatic send(input logic [1:0] h);
        serdes_rx_hdr = h;
        sb_q.push_back(model_step(h));
        pushed++;
        @(negedge rx_clk);
    endtask

    task automatic do_reset(input string tag);
        rx_rst_n = 1'b0;
        #1;
        check({tag, "_rst_lock"},    rx_block_lock,       0);
        check({tag, "_rst_bitslip"}, serdes_rx_bitslip,   0);
        check({tag, "_rst_rreq"},    serdes_rx_reset_req, 0);
        check({tag, "_rst_inv"},     rx_hdr_invalid,      0);
        check({tag, "_rst_cnt"},     rx_slip_count,       0);
        model_reset();
        @(negedge rx_clk);
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
    endtask

    function automatic logic [1:0] rand_hdr(input int ber_per_10k);
        if (int'($urandom_range(9999)) < ber_per_10k)
            return ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
        else
            return ($urandom_range(1) == 1) ? 2'b10 : 2'b01;
    endfunction

    // Monitor: every rising edge that consumed a header yields one output word.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge rx_clk);
            #1;
            if (rx_rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {rx_block_lock, serdes_rx_bitslip, serdes_rx_reset_req,
                     rx_hdr_invalid, rx_slip_count};
                popped++;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard hdr#%0d actual lock=%b slip=%b rreq=%b inv=%b cnt=%0d required lock=%b slip=%b rreq=%b inv=%b cnt=%0d",
                             popped, a.lock, a.slip, a.rreq, a.inv, a.cnt,
                             e.lock, e.slip, e.rreq, e.inv, e.cnt);
                end
                if (serdes_rx_bitslip)   slip_hi_seen++;
                if (serdes_rx_reset_req) rreq_seen++;
            end
        end
    end

    initial begin
        model_reset();
        @(negedge rx_clk);

        // 1: clean data locks after 64 headers, no slips
        do_reset("t1");
        slip_hi_seen = 0;
        repeat (LOCK_CNT - 1) send(2'b10);
        check("t1_lock_before", rx_block_lock, 0);
        send(2'b10);
        check("t1_lock", rx_block_lock, 1);
        check("t1_no_bitslip", slip_hi_seen, 0);

        // 2: single bad header causes one slip, then lock clears slip count
        do_reset("t2");
        slip_hi_seen = 0;
        repeat (10) send(2'b10);
        send(2'b11);
        check("t2_bitslip_hi", serdes_rx_bitslip, 1);
        check("t2_slip_cnt", rx_slip_count, 1);
        send(2'b10);
        check("t2_bitslip_lo", serdes_rx_bitslip, 0);
        repeat (HIGH + LOW - 1) send(2'b10);
        check("t2_slip_pulses", slip_hi_seen, 1);
        repeat (LOCK_CNT - 1) send(2'b10);
        check("t2_lock_before", rx_block_lock, 0);
        send(2'b10);
        check("t2_lock", rx_block_lock, 1);
        check("t2_slip_cnt_clr", rx_slip_count, 0);

        // 3: 15 bad headers in a window hold lock; next window starts fresh
        for (int i = 0; i < LOCK_CNT; i++)
            send(((i % 4) == 0 && i < 60) ? 2'b11 : 2'b10);
        check("t3_lock_held", rx_block_lock, 1);
        repeat (INV_LIM - 1) send(2'b00);
        check("t3_inv_flag", rx_hdr_invalid, 1);
        repeat (LOCK_CNT - INV_LIM + 1) send(2'b01);
        check("t3_lock_held2", rx_block_lock, 1);

        // 4: 16th bad header in a window drops lock and triggers a slip
        repeat (10) send(2'b10);
        for (int k = 0; k < INV_LIM; k++) begin
            if (k == INV_LIM - 1) check("t4_lock_pre", rx_block_lock, 1);
            send(2'b00);
            if (k < INV_LIM - 1) repeat (2) send(2'b01);
        end
        check("t4_lock_lost", rx_block_lock, 0);
        check("t4_bitslip", serdes_rx_bitslip, 1);
        check("t4_slip_cnt", rx_slip_count, 1);
        repeat (HIGH + LOW) send(2'b10);

        // 5: permanent garbage -> reset request on the 66th slip
        do_reset("t5");
        rreq_seen = 0;
        repeat ((SLIP_LIMIT - 1) * (1 + HIGH + LOW)) send(2'b00);
        check("t5_no_rreq_yet", rreq_seen, 0);
        check("t5_cnt_65", rx_slip_count, SLIP_LIMIT - 1);
        send(2'b00);
        check("t5_rreq", serdes_rx_reset_req, 1);
        check("t5_cnt_clr", rx_slip_count, 0);
        repeat (HIGH + LOW) send(2'b00);
        send(2'b00);
        check("t5_cnt_restart", rx_slip_count, 1);
        check("t5_rreq_once", rreq_seen, 1);

        // 6: reset mid-slip and while locked, then re-acquire
        do_reset("t6");
        send(2'b11);
        check("t6_bitslip_hi", serdes_rx_bitslip, 1);
        do_reset("t6_slip");
        repeat (LOCK_CNT) send(2'b10);
        check("t6_relock1", rx_block_lock, 1);
        do_reset("t6_lock");
        repeat (LOCK_CNT) send(2'b01);
        check("t6_relock2", rx_block_lock, 1);

        // Random BER sweep
        do_reset("ber1");
        repeat (2000) send(rand_hdr(100));
        check("ber1_lock_held", rx_block_lock, 1);
        repeat (2000) send(rand_hdr(500));

        @(negedge rx_clk);
        check("sb_drained", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
